// File: rtl/fp_add_pipe.sv
// ============================================================================
// Module      : fp_add_pipe
// Description : 3-stage pipelined IEEE-754 style adder/subtractor with RNE
//               rounding, flush-to-zero and a global stall. Define
//               FP_ADD_PIPE_FLAGS_EN to build the {invalid, overflow, inexact}
//               flag logic; otherwise flags read 3'b000.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_pipe #(
    parameter int EXP_LEN  = 5,
    parameter int MANT_LEN = 10,
    localparam int FLOAT_LEN = 1 + EXP_LEN + MANT_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] a,
    input  logic [FLOAT_LEN-1:0] b,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOAT_LEN-1:0] result,
    output logic [2:0]           flags
);

    localparam int E     = EXP_LEN;
    localparam int M     = MANT_LEN;
    localparam int SIG_W = M + 4;
    localparam int XW    = E + 2;
    localparam int LZW   = $clog2(SIG_W);
    localparam logic [E-1:0] c_exp_ones = '1;

    logic w_en;
    assign w_en      = out_ready || !out_valid;
    assign in_ready  = w_en;

    // ---------------- S1: unpack, special detect, align ----------------
    logic           w_sa, w_sb, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_a_ge, w_lost;
    logic [E-1:0]   w_ea, w_eb, w_efa, w_efb, w_es, w_diff;
    logic [M:0]     w_siga, w_sigb, w_sig_s;
    logic [SIG_W-1:0] w_s_ext, w_s_sh;

    logic             sign1_d, sub1_d, inv1_d, inf1_d, infs1_d;
    logic [E-1:0]     exp1_d;
    logic [SIG_W-1:0] sigl1_d, sigs1_d;

    assign w_sa    = a[FLOAT_LEN-1];
    assign w_sb    = b[FLOAT_LEN-1] ^ op_sub;
    assign w_ea    = a[FLOAT_LEN-2 -: E];
    assign w_eb    = b[FLOAT_LEN-2 -: E];
    assign w_nan_a = (w_ea == c_exp_ones) && (a[M-1:0] != '0);
    assign w_nan_b = (w_eb == c_exp_ones) && (b[M-1:0] != '0);
    assign w_inf_a = (w_ea == c_exp_ones) && (a[M-1:0] == '0);
    assign w_inf_b = (w_eb == c_exp_ones) && (b[M-1:0] == '0);
    assign w_siga  = {w_ea != '0, a[M-1:0]};
    assign w_sigb  = {w_eb != '0, b[M-1:0]};
    assign w_efa   = (w_ea == '0) ? E'(1) : w_ea;
    assign w_efb   = (w_eb == '0) ? E'(1) : w_eb;
    assign w_a_ge  = {w_efa, w_siga} >= {w_efb, w_sigb};

    assign sign1_d = w_a_ge ? w_sa : w_sb;
    assign exp1_d  = w_a_ge ? w_efa : w_efb;
    assign w_es    = w_a_ge ? w_efb : w_efa;
    assign w_sig_s = w_a_ge ? w_sigb : w_siga;
    assign sigl1_d = {(w_a_ge ? w_siga : w_sigb), 3'b000};
    assign w_diff  = exp1_d - w_es;

    // Everything pushed past the sticky position collapses into it.
    assign w_s_ext = {w_sig_s, 3'b000};
    assign w_s_sh  = w_s_ext >> w_diff;
    assign w_lost  = (w_s_ext & ~({SIG_W{1'b1}} << w_diff)) != '0;
    assign sigs1_d = {w_s_sh[SIG_W-1:1], w_s_sh[0] | w_lost};

    assign sub1_d  = w_sa != w_sb;
    assign inv1_d  = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb));
    assign inf1_d  = w_inf_a || w_inf_b;
    assign infs1_d = w_inf_a ? w_sa : w_sb;

    logic             v1_q, sign1_q, sub1_q, inv1_q, inf1_q, infs1_q;
    logic [E-1:0]     exp1_q;
    logic [SIG_W-1:0] sigl1_q, sigs1_q;

    // ---------------- S2: add/subtract, normalize ----------------
    logic [SIG_W:0]   w_sum;
    logic [LZW-1:0]   w_lz;
    logic             sign2_d, zero2_d;
    logic [XW-1:0]    exp2_d;
    logic [SIG_W-1:0] norm2_d;

    assign w_sum = sub1_q ? ({1'b0, sigl1_q} - {1'b0, sigs1_q})
                          : ({1'b0, sigl1_q} + {1'b0, sigs1_q});

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < SIG_W; i++) begin
            if (w_sum[i]) w_lz = LZW'(SIG_W - 1 - i);
        end
    end

    // Left shifts beyond one only occur when alignment was <= 1, so no sticky is smeared.
    always_comb begin
        zero2_d = (w_sum == '0);
        sign2_d = (zero2_d && sub1_q) ? 1'b0 : sign1_q;
        if (w_sum[SIG_W]) begin
            norm2_d = {w_sum[SIG_W:2], w_sum[1] | w_sum[0]};
            exp2_d  = {2'b00, exp1_q} + XW'(1);
        end else begin
            norm2_d = w_sum[SIG_W-1:0] << w_lz;
            exp2_d  = {2'b00, exp1_q} - XW'(w_lz);
        end
    end

    logic             v2_q, sign2_q, zero2_q, inv2_q, inf2_q, infs2_q;
    logic [XW-1:0]    exp2_q;
    logic [SIG_W-1:0] norm2_q;

    // ---------------- S3: round to nearest even, pack ----------------
    logic           w_g, w_rs, w_up, w_ovf, w_unf;
    logic [M+1:0]   w_sig_r;
    logic [XW-1:0]  w_exp_r;
    logic [M-1:0]   w_mant_r;
    logic [FLOAT_LEN-1:0] res_d;

    assign w_g      = norm2_q[2];
    assign w_rs     = |norm2_q[1:0];
    assign w_up     = w_g && (w_rs || norm2_q[3]);
    assign w_sig_r  = {1'b0, norm2_q[SIG_W-1:3]} + (M+2)'(w_up);
    assign w_exp_r  = exp2_q + XW'(w_sig_r[M+1]);
    assign w_mant_r = w_sig_r[M+1] ? w_sig_r[M:1] : w_sig_r[M-1:0];
    assign w_ovf    = !w_exp_r[XW-1] && (w_exp_r >= {2'b00, c_exp_ones});
    assign w_unf    = w_exp_r[XW-1] || (w_exp_r == '0);

    always_comb begin
        res_d = {sign2_q, w_exp_r[E-1:0], w_mant_r};
        if (inv2_q)       res_d = {1'b0, c_exp_ones, 1'b1, {(M-1){1'b0}}};
        else if (inf2_q)  res_d = {infs2_q, c_exp_ones, {M{1'b0}}};
        else if (zero2_q) res_d = {sign2_q, {(E+M){1'b0}}};
        else if (w_ovf)   res_d = {sign2_q, c_exp_ones, {M{1'b0}}};
        else if (w_unf)   res_d = {sign2_q, {(E+M){1'b0}}};
    end

    logic                 v3_q;
    logic [FLOAT_LEN-1:0] result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; sign1_q <= 1'b0; sub1_q <= 1'b0; inv1_q <= 1'b0;
            inf1_q <= 1'b0; infs1_q <= 1'b0; exp1_q <= '0; sigl1_q <= '0; sigs1_q <= '0;
            v2_q <= 1'b0; sign2_q <= 1'b0; zero2_q <= 1'b0; inv2_q <= 1'b0;
            inf2_q <= 1'b0; infs2_q <= 1'b0; exp2_q <= '0; norm2_q <= '0;
            v3_q <= 1'b0; result_q <= '0;
        end else if (w_en) begin
            v1_q    <= in_valid;
            sign1_q <= sign1_d;
            sub1_q  <= sub1_d;
            inv1_q  <= inv1_d;
            inf1_q  <= inf1_d;
            infs1_q <= infs1_d;
            exp1_q  <= exp1_d;
            sigl1_q <= sigl1_d;
            sigs1_q <= sigs1_d;
            v2_q    <= v1_q;
            sign2_q <= sign2_d;
            zero2_q <= zero2_d;
            inv2_q  <= inv1_q;
            inf2_q  <= inf1_q;
            infs2_q <= infs1_q;
            exp2_q  <= exp2_d;
            norm2_q <= norm2_d;
            v3_q    <= v2_q;
            result_q <= res_d;
        end
    end

    assign out_valid = v3_q;
    assign result    = result_q;

`ifdef FP_ADD_PIPE_FLAGS_EN
    logic [2:0] flg_d;
    logic [2:0] flags_q;

    always_comb begin
        flg_d = {2'b00, w_g || w_rs};
        if (inv2_q)                 flg_d = 3'b100;
        else if (inf2_q || zero2_q) flg_d = 3'b000;
        else if (w_ovf)             flg_d = 3'b011;
        else if (w_unf)             flg_d = 3'b001;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     flags_q <= 3'b000;
        else if (w_en)  flags_q <= flg_d;
    end

    assign flags = flags_q;
`else
    assign flags = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
// ============================================================================
// Module      : tb_fp_add_pipe
// Description : Scoreboard bench for fp_add_pipe (half and single precision).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_pipe;

`ifdef FP_ADD_PIPE_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready, out_valid;
    logic [15:0] result;
    logic [2:0]  flags;

    logic        in_valid32 = 1'b0;
    logic        op_sub32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        in_ready32, out_valid32;
    logic [31:0] result32;
    logic [2:0]  flags32;

    always #5 clk = ~clk;

    fp_add_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    fp_add_pipe #(.EXP_LEN(8), .MANT_LEN(23)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .op_sub(op_sub32), .out_valid(out_valid32),
        .out_ready(1'b1), .result(result32), .flags(flags32)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  flg;
    } exp_t;

    vec_t vecs [20] = '{
        '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000},
        '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000},
        '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 3'b100},
        '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011},
        '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001},
        '{16'h3C00, 16'h1400, 1'b0, 16'h3C01, 3'b000},
        '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001},
        '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 3'b000},
        '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000},
        '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 3'b100},
        '{16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 3'b000},
        '{16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 3'b000},
        '{16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000},
        '{16'h8000, 16'h0000, 1'b0, 16'h0000, 3'b000},
        '{16'h0400, 16'h03FF, 1'b1, 16'h0000, 3'b001},
        '{16'h0200, 16'h0200, 1'b0, 16'h0400, 3'b000},
        '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b001},
        '{16'h7BFF, 16'h3C00, 1'b0, 16'h7BFF, 3'b001},
        '{16'h7BFF, 16'h5000, 1'b0, 16'h7C00, 3'b011},
        '{16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 3'b011}
    };

    exp_t sb_q[$];
    exp_t drv_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs compared against the scoreboard head every valid cycle, popped on transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("in_ready", 32'(in_ready), 32'(out_ready || !out_valid));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    check_eq("result", 32'(result), 32'(sb_q[0].res));
                    check_eq("flags", 32'(flags), FLAGS_ON ? 32'(sb_q[0].flg) : 32'd0);
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) sb_q.push_back(drv_exp);
        end
    end

    task automatic send(input int idx);
        in_valid    = 1'b1;
        a           = vecs[idx].a;
        b           = vecs[idx].b;
        op_sub      = vecs[idx].sub;
        drv_exp.res = vecs[idx].res;
        drv_exp.flg = vecs[idx].flg;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check_eq("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic latency_check(input int idx, input string tag);
        int k;
        send(idx);
        for (k = 1; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check_eq(tag, 32'(k), 32'd3);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        check_eq("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        latency_check(0, "latency_first");
        drain();

        for (int i = 1; i < 20; i++) send(i);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) send(i);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        for (int i = 8; i < 11; i++) send(i);
        @(negedge clk);
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        latency_check(11, "latency_post_reset");
        drain();

        check_eq("sp_in_ready", 32'(in_ready32), 32'd1);
        in_valid32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40000000; op_sub32 = 1'b0;
        @(posedge clk); #1;
        a32 = 32'h40400000; b32 = 32'h3F800000; op_sub32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        for (k = 2; k < 10; k++) begin
            @(negedge clk);
            if (out_valid32) break;
        end
        check_eq("sp_latency", 32'(k), 32'd3);
        check_eq("sp_add", result32, 32'h40400000);
        check_eq("sp_add_flags", 32'(flags32), 32'd0);
        @(negedge clk);
        check_eq("sp_sub", result32, 32'h40000000);
        check_eq("sp_sub_valid", 32'(out_valid32), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
